// File: rtl/uart_arb_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
// The states are IDLE, START and WAIT_DONE.
package uart_arb_pkg;

   localparam int NREQ          = 4;
   localparam int DATA_W        = 8;
   localparam int TIMEOUT_TICKS = 200;

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_DONE
   } state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector. The search starts at last+1 and
// wraps around to 0.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          found
);

   int          p;
   logic [IW-1:0] pi;

   // Scan from the farthest offset down, so the nearest match is written last.
   always_comb begin
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      p      = 0;
      pi     = '0;
      for (int off = N; off >= 1; off--) begin
         p = int'(last) + off;
         if (p >= N) p = p - N;
         pi = p[IW-1:0];
         if (req[pi]) begin
            onehot     = '0;
            onehot[pi] = 1'b1;
            idx        = pi;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NREQ requesters.
// Defining UART_ARB_TIMEOUT_EN adds a baudTick watchdog and a sticky timeout_err flag.
module uart_tx_arbiter #(
   parameter int NREQ          = uart_arb_pkg::NREQ,
   parameter int DATA_W        = uart_arb_pkg::DATA_W,
   parameter int TIMEOUT_TICKS = uart_arb_pkg::TIMEOUT_TICKS
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     baudTick,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*DATA_W-1:0]   req_data,
   output logic [NREQ-1:0]          req_ready,
   output logic                     tx_start,
   output logic [DATA_W-1:0]        tx_data,
   input  logic                     tx_done,
   output logic [NREQ-1:0]          grant,
   output logic                     busy,
   output logic                     timeout_err
);

   import uart_arb_pkg::*;

   localparam int IW = $clog2(NREQ);

   state_e            state_q, state_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [NREQ-1:0]   ready_q, ready_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [IW-1:0]     last_q, last_d;
   logic [IW-1:0]     owner_q, owner_d;

   logic [NREQ-1:0]   win_oh;
   logic [IW-1:0]     win_idx;
   logic              win_any;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_TICKS + 1);
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              err_q, err_d;
`else
   logic              unused_tick;
   assign unused_tick = baudTick;
`endif

   rr_pick #(
      .N  (NREQ),
      .IW (IW)
   ) u_pick (
      .req    (req_valid),
      .last   (last_q),
      .onehot (win_oh),
      .idx    (win_idx),
      .found  (win_any)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ready_d = '0;
      data_d  = data_q;
      last_d  = last_q;
      owner_d = owner_q;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (win_any) begin
               data_d  = req_data[int'(win_idx)*DATA_W +: DATA_W];
               grant_d = win_oh;
               ready_d = win_oh;
               owner_d = win_idx;
               state_d = START;
`ifdef UART_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         START: begin
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (tx_done) begin
               last_d  = owner_q;
               grant_d = '0;
               state_d = IDLE;
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (baudTick) begin
               // Abort the stuck frame and hand the line to the next requester.
               if (cnt_q == CW'(TIMEOUT_TICKS - 1)) begin
                  err_d   = 1'b1;
                  last_d  = owner_q;
                  grant_d = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
`endif
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         ready_q <= '0;
         data_q  <= '0;
         last_q  <= IW'(NREQ - 1);
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ready_q <= ready_d;
         data_q  <= data_d;
         last_q  <= last_d;
         owner_q <= owner_d;
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign timeout_err = err_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign req_ready = ready_q;
   assign tx_start  = (state_q == START);
   assign tx_data   = data_q;
   assign grant     = grant_q;
   assign busy      = (state_q != IDLE);

endmodule
